// File: rtl/stream_demux_pkg.sv
// Shared types, default widths and helpers for the stream demultiplexer.
// Latency: n/a (no logic).
// Backpressure: n/a.
// Contents: slot_state_e, DEF_* default widths, sel_fits().
package stream_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DEF_N_OUT  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_CNT_W  = 16;

  // True when a select value addresses an existing output channel.
  function automatic logic sel_fits(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered slot: holds a single beat for one output channel.
// Latency: 1 clock from load_i to valid_o.
// Backpressure: free_o is high when empty or draining this clock, so a ready consumer sustains 1 beat/clock.
// Ports: clk, rst_n (sync, active-low), load_i/data_i (write), ready_i (consumer),
//        free_o (can accept this clock), valid_o/data_o (slot contents).
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              free_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign free_o  = (state_q == SLOT_EMPTY) || ready_i;
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      // A load wins over a simultaneous drain: the slot stays full with new data.
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if ((state_q == SLOT_FULL) && ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to one of N_OUT registered output channels by up_sel.
// Latency: 1 clock from acceptance to dn_valid; per-channel slots absorb downstream stalls independently.
// Backpressure: up_ready follows the selected slot's free flag; out-of-range selects are always accepted and dropped.
// Ports: clk, rst_n (sync, active-low); up_valid/up_ready/up_sel/up_data (upstream);
//        dn_valid/dn_ready/dn_data (per channel, channel k at [k*DATA_W +: DATA_W]);
//        err_bad_sel (sticky bad-select flag); cnt (per-channel saturating load counters,
//        only when STREAM_DEMUX_STATS_EN is defined, which also adds parameter CNT_W).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
`ifdef STREAM_DEMUX_STATS_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [SEL_W-1:0]        up_sel,
  input  logic [DATA_W-1:0]       up_data,
  output logic [N_OUT-1:0]        dn_valid,
  input  logic [N_OUT-1:0]        dn_ready,
  output logic [N_OUT*DATA_W-1:0] dn_data,
  output logic                    err_bad_sel
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  cnt
`endif
);

  logic             sel_ok;
  logic             accept;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             err_q, err_d;

  assign sel_ok = sel_fits(32'(up_sel), N_OUT);

  // up_ready deliberately ignores up_valid; a bad select never stalls.
  always_comb begin
    up_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (32'(up_sel) == k) up_ready = free[k];
    end
  end

  assign accept = up_valid && up_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept && (32'(up_sel) == k);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .data_i  (up_data),
      .ready_i (dn_ready[k]),
      .free_o  (free[k]),
      .valid_o (dn_valid[k]),
      .data_o  (dn_data[k*DATA_W +: DATA_W])
    );
  end

  assign err_d       = err_q || (accept && !sel_ok);
  assign err_bad_sel = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] cnt_d [N_OUT];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (load[k] && (cnt_q[k] != {CNT_W{1'b1}})) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      if (!rst_n) cnt_q[k] <= '0;
      else        cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    assign cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing, throughput,
// isolation and counters, and a 3-channel instance for out-of-range selects.
// Inputs change 1ns after posedge; outputs are sampled mid-cycle.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        up_valid, up_ready;
  logic [1:0]  up_sel;
  logic [7:0]  up_data;
  logic [3:0]  dn_valid, dn_ready;
  logic [31:0] dn_data;
  logic        err_bad_sel;

  logic        b_up_valid, b_up_ready;
  logic [1:0]  b_up_sel;
  logic [7:0]  b_up_data;
  logic [2:0]  b_dn_valid, b_dn_ready;
  logic [23:0] b_dn_data;
  logic        b_err_bad_sel;

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] cnt;
  logic [11:0] b_cnt;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  stream_demux #(
    .N_OUT(4), .DATA_W(8), .SEL_W(2)
`ifdef STREAM_DEMUX_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_sel(up_sel), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .err_bad_sel(err_bad_sel)
`ifdef STREAM_DEMUX_STATS_EN
    , .cnt(cnt)
`endif
  );

  stream_demux #(
    .N_OUT(3), .DATA_W(8), .SEL_W(2)
`ifdef STREAM_DEMUX_STATS_EN
    , .CNT_W(4)
`endif
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_sel(b_up_sel), .up_data(b_up_data),
    .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_data(b_dn_data),
    .err_bad_sel(b_err_bad_sel)
`ifdef STREAM_DEMUX_STATS_EN
    , .cnt(b_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up_valid = 1'b1; up_sel = 2'd2; up_data = 8'hFF; dn_ready = 4'h0;
    b_up_valid = 1'b1; b_up_sel = 2'd1; b_up_data = 8'hFF; b_dn_ready = 3'h0;
    cyc(); cyc();
    check_cnt++; if (dn_valid !== 4'h0) $display("FAIL reset_dn_valid got=%h want=0", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'h0) $display("FAIL reset_dn_data got=%h want=0", dn_data); else pass_cnt++;
    check_cnt++; if (err_bad_sel !== 1'b0) $display("FAIL reset_err got=%b want=0", err_bad_sel); else pass_cnt++;
    check_cnt++; if (b_dn_valid !== 3'h0) $display("FAIL reset_b_dn_valid got=%h want=0", b_dn_valid); else pass_cnt++;
`ifdef STREAM_DEMUX_STATS_EN
    check_cnt++; if (cnt !== 16'h0) $display("FAIL reset_cnt got=%h want=0", cnt); else pass_cnt++;
`endif
    up_valid = 1'b0; b_up_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    check_cnt++; if (dn_valid !== 4'h0) $display("FAIL reset_no_load got=%h want=0", dn_valid); else pass_cnt++;
  endtask

  task automatic test_route();
    dn_ready = 4'h0;
    up_valid = 1'b1; up_sel = 2'd2; up_data = 8'hA5;
    #2;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL route_rdy_empty got=%b want=1", up_ready); else pass_cnt++;
    cyc();
    check_cnt++; if (dn_valid !== 4'b0100) $display("FAIL route_valid got=%b want=0100", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data[23:16] !== 8'hA5) $display("FAIL route_data got=%h want=a5", dn_data[23:16]); else pass_cnt++;
    up_data = 8'h5A;
    #2;
    check_cnt++; if (up_ready !== 1'b0) $display("FAIL route_rdy_full got=%b want=0", up_ready); else pass_cnt++;
    cyc();
    check_cnt++; if (dn_data[23:16] !== 8'hA5) $display("FAIL route_stall_hold got=%h want=a5", dn_data[23:16]); else pass_cnt++;
    check_cnt++; if (dn_valid !== 4'b0100) $display("FAIL route_stall_valid got=%b want=0100", dn_valid); else pass_cnt++;
    dn_ready = 4'b0100;
    #2;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL route_rdy_drain got=%b want=1", up_ready); else pass_cnt++;
    cyc();
    check_cnt++; if (dn_valid !== 4'b0100 || dn_data[23:16] !== 8'h5A)
      $display("FAIL route_reload got=%b/%h want=0100/5a", dn_valid, dn_data[23:16]); else pass_cnt++;
    up_valid = 1'b0;
    cyc();
    check_cnt++; if (dn_valid !== 4'b0000) $display("FAIL route_empty got=%b want=0000", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data[23:16] !== 8'h5A) $display("FAIL route_empty_hold got=%h want=5a", dn_data[23:16]); else pass_cnt++;
    dn_ready = 4'h0;
  endtask

  task automatic test_back_to_back();
    dn_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      up_valid = 1'b1; up_sel = 2'd1; up_data = 8'(8'h10 + i);
      #2;
      check_cnt++; if (up_ready !== 1'b1) $display("FAIL b2b_rdy beat=%0d got=%b want=1", i, up_ready); else pass_cnt++;
      cyc();
      check_cnt++; if (dn_valid !== 4'b0010 || dn_data[15:8] !== 8'(8'h10 + i))
        $display("FAIL b2b_out beat=%0d got=%b/%h want=0010/%h", i, dn_valid, dn_data[15:8], 8'(8'h10 + i)); else pass_cnt++;
    end
    up_valid = 1'b0;
    cyc();
    check_cnt++; if (dn_valid !== 4'h0) $display("FAIL b2b_drained got=%b want=0000", dn_valid); else pass_cnt++;
  endtask

  task automatic test_isolation();
    dn_ready = 4'h0;
    up_valid = 1'b1; up_sel = 2'd0; up_data = 8'h3C;
    cyc();
    dn_ready = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      up_sel = 2'd3; up_data = 8'(8'hC1 + i);
      #2;
      check_cnt++; if (up_ready !== 1'b1) $display("FAIL iso_rdy beat=%0d got=%b want=1", i, up_ready); else pass_cnt++;
      cyc();
      check_cnt++; if (dn_valid !== 4'b1001 || dn_data[31:24] !== 8'(8'hC1 + i) || dn_data[7:0] !== 8'h3C)
        $display("FAIL iso_out beat=%0d got=%b/%h/%h want=1001/%h/3c", i, dn_valid, dn_data[31:24], dn_data[7:0], 8'(8'hC1 + i));
      else pass_cnt++;
    end
    up_valid = 1'b0; up_sel = 2'd0;
    #2;
    check_cnt++; if (up_ready !== 1'b0) $display("FAIL iso_ch0_blocked got=%b want=0", up_ready); else pass_cnt++;
    dn_ready = 4'hF;
    cyc(); cyc();
    check_cnt++; if (dn_valid !== 4'h0) $display("FAIL iso_drained got=%b want=0000", dn_valid); else pass_cnt++;
  endtask

  task automatic test_bad_sel();
    b_dn_ready = 3'h0;
    b_up_valid = 1'b1; b_up_sel = 2'd1; b_up_data = 8'h77;
    cyc();
    b_up_sel = 2'd3; b_up_data = 8'hEE;
    #2;
    check_cnt++; if (b_up_ready !== 1'b1) $display("FAIL bad_rdy got=%b want=1", b_up_ready); else pass_cnt++;
    check_cnt++; if (b_err_bad_sel !== 1'b0) $display("FAIL bad_err_early got=%b want=0", b_err_bad_sel); else pass_cnt++;
    cyc();
    b_up_valid = 1'b0;
    check_cnt++; if (b_err_bad_sel !== 1'b1) $display("FAIL bad_err_set got=%b want=1", b_err_bad_sel); else pass_cnt++;
    check_cnt++; if (b_dn_valid !== 3'b010 || b_dn_data !== 24'h007700)
      $display("FAIL bad_no_change got=%b/%h want=010/007700", b_dn_valid, b_dn_data); else pass_cnt++;
`ifdef STREAM_DEMUX_STATS_EN
    check_cnt++; if (b_cnt !== 12'h010) $display("FAIL bad_cnt got=%h want=010", b_cnt); else pass_cnt++;
`endif
    cyc(); cyc(); cyc();
    check_cnt++; if (b_err_bad_sel !== 1'b1) $display("FAIL bad_err_sticky got=%b want=1", b_err_bad_sel); else pass_cnt++;
  endtask

`ifdef STREAM_DEMUX_STATS_EN
  task automatic test_stats();
    // Prior loads: ch0=1, ch1=8, ch2=2, ch3=2.
    dn_ready = 4'hF;
    for (int i = 0; i < 20; i++) begin
      up_valid = 1'b1; up_sel = 2'd0; up_data = 8'(i);
      cyc();
      if (i == 9) begin
        check_cnt++; if (cnt[3:0] !== 4'd11) $display("FAIL stats_mid got=%0d want=11", cnt[3:0]); else pass_cnt++;
      end
    end
    up_valid = 1'b0;
    cyc();
    check_cnt++; if (cnt !== 16'h228F) $display("FAIL stats_sat got=%h want=228f", cnt); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    dn_ready = 4'h0;
    up_valid = 1'b1; up_sel = 2'd0; up_data = 8'h99;
    cyc();
    check_cnt++; if (dn_valid !== 4'b0001) $display("FAIL mid_pre_valid got=%b want=0001", dn_valid); else pass_cnt++;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; up_valid = 1'b0;
    check_cnt++; if (dn_valid !== 4'h0 || b_dn_valid !== 3'h0)
      $display("FAIL mid_valid got=%b/%b want=0000/000", dn_valid, b_dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'h0) $display("FAIL mid_data got=%h want=0", dn_data); else pass_cnt++;
    check_cnt++; if (b_err_bad_sel !== 1'b0) $display("FAIL mid_err got=%b want=0", b_err_bad_sel); else pass_cnt++;
`ifdef STREAM_DEMUX_STATS_EN
    check_cnt++; if (cnt !== 16'h0 || b_cnt !== 12'h0) $display("FAIL mid_cnt got=%h/%h want=0/0", cnt, b_cnt); else pass_cnt++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_route();
    test_back_to_back();
    test_isolation();
    test_bad_sel();
`ifdef STREAM_DEMUX_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
